nxm_status: RTL



---
 rtl/nxm_status.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/nxm_status.sv
`default_nettype none
// ============================================================================
// Module   : nxm_status
// Purpose  : Downstream consumer of the NXM bus monitor. Snapshots the
//            address of every CPU request, latches the address of the first
//            non-existent-memory cycle, keeps sticky error / overflow /
//            saturating event-count status readable and clearable by the CPU,
//            and raises a trap request toward microcode with a req/ack
//            handshake.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            cpuADDRO[0:35]    - CPU bus address (bits 14:35 are captured)
//            cpuREQO           - CPU bus request
//            nxmINTR           - one-cycle NXM timeout pulse
//            nxmTACK           - trap acknowledge from microcode
//            csrWR             - status write strobe
//            csrDATAI[0:35]    - write data, bit 0 = clear
//            csrDATAO[0:35]    - status read data
//            nxmTRAP           - trap request (level, registered)
//            nxmERR            - sticky error flag
// Revision : 1.0 - initial release
// ============================================================================
module nxm_status #(
  parameter int CNTW   = 4,
  parameter int TRAPEN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:35] cpuADDRO,
  input  logic        cpuREQO,
  input  logic        nxmINTR,
  input  logic        nxmTACK,
  input  logic        csrWR,
  input  logic [0:35] csrDATAI,
  output logic [0:35] csrDATAO,
  output logic        nxmTRAP,
  output logic        nxmERR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HELD = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  state_t          state_q, state_d;
  logic            req_dly_q, req_dly_d;
  logic [21:0]     req_addr_q, req_addr_d;
  logic [21:0]     err_addr_q, err_addr_d;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            trap_q, trap_d;

  logic            clr;
  logic            first_evt;
  logic            unused_bits;

  // Only the low 22 address bits and the clear bit are architecturally used.
  assign unused_bits = ^{cpuADDRO[0:13], csrDATAI[1:35]};

  assign clr = csrWR & csrDATAI[0];

  // An event counts as "first" when nothing is latched yet, or when a clear
  // lands in the same cycle: the new event wins over the clear.
  assign first_evt = nxmINTR & ((state_q == IDLE) | clr);

  // --------------------------------------------------------------------------
  // Request snapshot: capture the address once per request rising edge.
  // --------------------------------------------------------------------------
  always_comb begin
    req_dly_d  = cpuREQO;
    req_addr_d = req_addr_q;
    if (cpuREQO && !req_dly_q) begin
      req_addr_d = cpuADDRO[14:35];
    end
  end

  // --------------------------------------------------------------------------
  // Status / FSM next-state logic.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    err_addr_d = err_addr_q;

    if (first_evt) begin
      err_d      = 1'b1;
      ovf_d      = 1'b0;
      cnt_d      = CNT_ONE;
      err_addr_d = req_addr_q;
      state_d    = (TRAPEN != 0) ? PEND : HELD;
    end else if (clr) begin
      // errADDR is deliberately retained so software can still read it.
      err_d   = 1'b0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        PEND, HELD: begin
          if (nxmINTR) begin
            ovf_d = 1'b1;
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          if ((state_q == PEND) && nxmTACK) begin
            state_d = HELD;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    // Trap is a flop so no combinational path exists from nxmINTR/nxmTACK.
    trap_d = (TRAPEN != 0) && (state_d == PEND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_dly_q  <= 1'b0;
      req_addr_q <= '0;
      err_addr_q <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_dly_q  <= req_dly_d;
      req_addr_q <= req_addr_d;
      err_addr_q <= err_addr_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      trap_q     <= trap_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read-back word: bit 0 ERR, bit 1 OVF, count MSB-first from bit 2,
  // zero fill up to bit 13, errADDR in 14:35.
  // --------------------------------------------------------------------------
  always_comb begin
    csrDATAO       = '0;
    csrDATAO[0]    = err_q;
    csrDATAO[1]    = ovf_q;
    for (int i = 0; i < CNTW; i++) begin
      csrDATAO[2+i] = cnt_q[CNTW-1-i];
    end
    csrDATAO[14:35] = err_addr_q;
  end

  assign nxmTRAP = trap_q;
  assign nxmERR  = err_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && first_evt) begin
      $display("nxm_status: NXM latched, address %06o", req_addr_q);
    end
  end
`endif

endmodule
`default_nettype wire
